cuenta_unos_param: RTL

- Parametrised successor to the 3-bit ones-counter datapath.
- Counts the 1s (or, by mode, the 0s) in a WIDTH-bit operand using a shift register Q, an accumulator A and a hardwired three-state control unit.
- Adds a busy flag, terminates early once no 1s remain in Q, and restarts directly from the done state.
- Sits beside the existing arithmetic demo units as a multi-cycle coprocessor started by a one-cycle start pulse.

---
 rtl/cuenta_unos_param.sv | 78 +++++++
 1 files changed

// File: rtl/cuenta_unos_param.sv
// Multi-cycle ones/zeros counter: shifts the operand out of Q and accumulates
// the set bits in A, stopping as soon as no 1s remain in Q.
module cuenta_unos_param #(
   parameter  int WIDTH = 8,
   localparam int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] valor,
   input  logic             mode,
   output logic [CW-1:0]    cuenta,
   output logic             busy,
   output logic             fin
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] q;
   logic [CW-1:0]    a;
   logic             accept;
   logic             q_empty;

   // A restart is accepted from DONE as well as IDLE, so a held start chains operations.
   assign accept  = start && ((state == IDLE) || (state == DONE));
   assign q_empty = (q == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start)   state_next = COUNT;
         COUNT:   if (q_empty) state_next = DONE;
         DONE:    if (start)   state_next = COUNT;
         default:              state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      fin  = 1'b0;
      case (state)
         COUNT:   busy = 1'b1;
         DONE:    fin  = 1'b1;
         default: ;
      endcase
   end

   // A cannot overflow: at most WIDTH increments fit in CW bits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= '0;
         a <= '0;
      end else if (accept) begin
         q <= mode ? ~valor : valor;
         a <= '0;
      end else if ((state == COUNT) && !q_empty) begin
         a <= a + {{(CW-1){1'b0}}, q[0]};
         q <= q >> 1;
      end
   end

   assign cuenta = a;

endmodule
